// File: rtl/branch_issue_queue_pkg.sv
// ============================================================================
// branch_issue_queue_pkg : payload type carried by the branch issue queue
// Rev 1.0
// ============================================================================
`default_nettype none

package branch_issue_queue_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm_val;
        logic [4:0]  rd_addr;
        logic [4:0]  ROB_tag;
        logic        branch;
        logic        jump;
        logic        took_branch;
    } branch_entry_t;

endpackage

`default_nettype wire

// File: rtl/branch_issue_queue.sv
// ============================================================================
// branch_issue_queue : age-ordered reservation station feeding the branch unit
// Rev 1.0
// ============================================================================
`default_nettype none

module branch_issue_queue
    import branch_issue_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic                         clk_i,
    input  logic                         reset_ni,
    input  logic                         flush_i,
    input  logic                         disp_valid_i,
    output logic                         disp_ready_o,
    input  branch_entry_t                disp_data_i,
    input  logic [TAG_W-1:0]             disp_rs1_tag_i,
    input  logic [TAG_W-1:0]             disp_rs2_tag_i,
    input  logic                         disp_rs1_rdy_i,
    input  logic                         disp_rs2_rdy_i,
    input  logic                         cdb_valid_i,
    input  logic [TAG_W-1:0]             cdb_tag_i,
    input  logic [31:0]                  cdb_val_i,
    output logic                         issue_valid_o,
    input  logic                         issue_ready_i,
    output branch_entry_t                issue_data_o,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] rs1_rdy;
    logic [DEPTH-1:0] rs2_rdy;
    branch_entry_t    ent     [DEPTH];
    logic [TAG_W-1:0] rs1_tag [DEPTH];
    logic [TAG_W-1:0] rs2_tag [DEPTH];
    // older[i][j] = 1 : entry i was allocated before entry j
    logic [DEPTH-1:0] older   [DEPTH];
    logic [OCC_W-1:0] occ;

    logic [DEPTH-1:0] eligible;
    logic [DEPTH-1:0] sel;
    logic [IDX_W-1:0] alloc_idx;
    logic             disp_fire;
    logic             issue_fire;
    logic             cdb_live;
    branch_entry_t    new_ent;
    logic             new_rs1_rdy;
    logic             new_rs2_rdy;

    assign eligible      = valid & rs1_rdy & rs2_rdy;
    assign disp_ready_o  = !flush_i && (occ < FULL_OCC);
    assign disp_fire     = disp_valid_i && disp_ready_o;
    assign issue_valid_o = !flush_i && (|eligible);
    assign issue_fire    = issue_valid_o && issue_ready_i;
    assign cdb_live      = cdb_valid_i && !flush_i;
    assign occupancy_o   = occ;

    // Oldest eligible wins: an entry is blocked by any eligible entry older than it.
    always_comb begin
        sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sel[i] = eligible[i];
            for (int k = 0; k < DEPTH; k++) begin
                if (eligible[k] && older[k][i]) begin
                    sel[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        issue_data_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel[i]) begin
                issue_data_o = ent[i];
            end
        end
    end

    always_comb begin
        alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                alloc_idx = IDX_W'(i);
            end
        end
    end

    // Ops without an rs2 (JALR and non-branch ops) mark rs2 ready at dispatch.
    always_comb begin
        new_ent     = disp_data_i;
        new_rs1_rdy = disp_rs1_rdy_i;
        new_rs2_rdy = disp_rs2_rdy_i || disp_data_i.jump || !disp_data_i.branch;
        if (!new_rs1_rdy && cdb_live && (cdb_tag_i == disp_rs1_tag_i)) begin
            new_ent.rs1_val = cdb_val_i;
            new_rs1_rdy     = 1'b1;
        end
        if (!new_rs2_rdy && cdb_live && (cdb_tag_i == disp_rs2_tag_i)) begin
            new_ent.rs2_val = cdb_val_i;
            new_rs2_rdy     = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            valid   <= '0;
            rs1_rdy <= '0;
            rs2_rdy <= '0;
            occ     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent[i]     <= '0;
                rs1_tag[i] <= '0;
                rs2_tag[i] <= '0;
                older[i]   <= '0;
            end
        end else if (flush_i) begin
            valid <= '0;
            occ   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                older[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid[i] && !rs1_rdy[i] && cdb_valid_i && (rs1_tag[i] == cdb_tag_i)) begin
                    ent[i].rs1_val <= cdb_val_i;
                    rs1_rdy[i]     <= 1'b1;
                end
                if (valid[i] && !rs2_rdy[i] && cdb_valid_i && (rs2_tag[i] == cdb_tag_i)) begin
                    ent[i].rs2_val <= cdb_val_i;
                    rs2_rdy[i]     <= 1'b1;
                end
                if (issue_fire && sel[i]) begin
                    valid[i] <= 1'b0;
                end
            end
            if (disp_fire) begin
                valid[alloc_idx]   <= 1'b1;
                ent[alloc_idx]     <= new_ent;
                rs1_tag[alloc_idx] <= disp_rs1_tag_i;
                rs2_tag[alloc_idx] <= disp_rs2_tag_i;
                rs1_rdy[alloc_idx] <= new_rs1_rdy;
                rs2_rdy[alloc_idx] <= new_rs2_rdy;
                for (int k = 0; k < DEPTH; k++) begin
                    older[k][alloc_idx] <= valid[k];
                end
                older[alloc_idx] <= '0;
            end
            occ <= occ + OCC_W'(disp_fire) - OCC_W'(issue_fire);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_branch_issue_queue.sv
// Directed bench for branch_issue_queue; issued payloads are checked against a
// queue of expected records filled as the stimulus is driven.
`default_nettype none

module tb_branch_issue_queue;
    import branch_issue_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 5;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rob;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             flush;
    logic             disp_valid;
    logic             disp_ready;
    branch_entry_t    disp_data;
    logic [TAG_W-1:0] rs1_tag, rs2_tag;
    logic             rs1_rdy, rs2_rdy;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_val;
    logic             issue_valid;
    logic             issue_ready;
    branch_entry_t    issue_data;
    logic [2:0]       occ;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];

    branch_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk_i          (clk),
        .reset_ni       (reset_n),
        .flush_i        (flush),
        .disp_valid_i   (disp_valid),
        .disp_ready_o   (disp_ready),
        .disp_data_i    (disp_data),
        .disp_rs1_tag_i (rs1_tag),
        .disp_rs2_tag_i (rs2_tag),
        .disp_rs1_rdy_i (rs1_rdy),
        .disp_rs2_rdy_i (rs2_rdy),
        .cdb_valid_i    (cdb_valid),
        .cdb_tag_i      (cdb_tag),
        .cdb_val_i      (cdb_val),
        .issue_valid_o  (issue_valid),
        .issue_ready_i  (issue_ready),
        .issue_data_o   (issue_data),
        .occupancy_o    (occ)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic branch_entry_t mk(input logic [31:0] pc, input logic [31:0] v1,
                                         input logic [31:0] v2, input logic [4:0] rob,
                                         input logic br, input logic jmp);
        branch_entry_t e;
        e         = '0;
        e.pc      = pc;
        e.rs1_val = v1;
        e.rs2_val = v2;
        e.imm_val = 32'h10;
        e.rd_addr = 5'd1;
        e.ROB_tag = rob;
        e.branch  = br;
        e.jump    = jmp;
        return e;
    endfunction

    function automatic exp_t ex(input logic [31:0] pc, input logic [4:0] rob,
                                input logic [31:0] v1, input logic [31:0] v2);
        exp_t e;
        e.pc  = pc;
        e.rob = rob;
        e.rs1 = v1;
        e.rs2 = v2;
        return e;
    endfunction

    task automatic drive_disp(input branch_entry_t d, input logic r1, input logic [TAG_W-1:0] t1,
                              input logic r2, input logic [TAG_W-1:0] t2);
        disp_valid = 1'b1;
        disp_data  = d;
        rs1_rdy    = r1;
        rs1_tag    = t1;
        rs2_rdy    = r2;
        rs2_tag    = t2;
    endtask

    // Scoreboard: every issue handshake pops and compares the next expected record.
    always @(negedge clk) begin
        if (reset_n && issue_valid && issue_ready) begin
            chk("issue_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("issue_pc",  64'(issue_data.pc),      64'(e.pc));
                chk("issue_rob", 64'(issue_data.ROB_tag), 64'(e.rob));
                chk("issue_rs1", 64'(issue_data.rs1_val), 64'(e.rs1));
                chk("issue_rs2", 64'(issue_data.rs2_val), 64'(e.rs2));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n     = 1'b0;
        flush       = 1'b0;
        disp_valid  = 1'b0;
        disp_data   = '0;
        rs1_tag     = '0;
        rs2_tag     = '0;
        rs1_rdy     = 1'b0;
        rs2_rdy     = 1'b0;
        cdb_valid   = 1'b0;
        cdb_tag     = '0;
        cdb_val     = '0;
        issue_ready = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        chk("reset_occ",         64'(occ),         64'd0);
        chk("reset_issue_valid", 64'(issue_valid), 64'd0);
        chk("reset_disp_ready",  64'(disp_ready),  64'd1);
        chk("reset_issue_data",  64'(issue_data.pc), 64'd0);

        // Ready BNE: issues one cycle after dispatch
        issue_ready = 1'b1;
        drive_disp(mk(32'h100, 32'd5, 32'd5, 5'd10, 1'b1, 1'b0), 1'b1, 5'd0, 1'b1, 5'd0);
        exp_q.push_back(ex(32'h100, 5'd10, 32'd5, 32'd5));
        #1;
        chk("empty_same_cycle_no_issue", 64'(issue_valid), 64'd0);
        tick();
        disp_valid = 1'b0;
        chk("ready_occ_1",   64'(occ),         64'd1);
        chk("ready_issue_v", 64'(issue_valid), 64'd1);
        tick();
        chk("ready_occ_0",   64'(occ),         64'd0);

        // Out-of-order wakeup: older A waits on tag 3, younger B ready
        exp_q.push_back(ex(32'h204, 5'd2, 32'd1, 32'd2));
        exp_q.push_back(ex(32'h200, 5'd1, 32'h55, 32'd7));
        drive_disp(mk(32'h200, 32'd0, 32'd7, 5'd1, 1'b1, 1'b0), 1'b0, 5'd3, 1'b1, 5'd0);
        tick();
        drive_disp(mk(32'h204, 32'd1, 32'd2, 5'd2, 1'b1, 1'b0), 1'b1, 5'd0, 1'b1, 5'd0);
        tick();
        disp_valid = 1'b0;
        chk("ooo_b_selected", 64'(issue_data.pc), 64'h204);
        tick();
        chk("ooo_a_waiting", 64'(issue_valid), 64'd0);
        chk("ooo_occ_1",     64'(occ),         64'd1);
        cdb_valid = 1'b1;
        cdb_tag   = 5'd3;
        cdb_val   = 32'h55;
        #1;
        chk("ooo_wake_not_same_cycle", 64'(issue_valid), 64'd0);
        tick();
        cdb_valid = 1'b0;
        chk("ooo_a_ready", 64'(issue_valid), 64'd1);
        tick();
        chk("ooo_occ_0", 64'(occ), 64'd0);

        // Age priority: four entries wait on tag 7, then issue in allocation order
        for (int i = 0; i < 4; i++) begin
            drive_disp(mk(32'h300 + 32'(4 * i), 32'd0, 32'(i), 5'(20 + i), 1'b1, 1'b0),
                       1'b0, 5'd7, 1'b1, 5'd0);
            exp_q.push_back(ex(32'h300 + 32'(4 * i), 5'(20 + i), 32'h77, 32'(i)));
            tick();
        end
        disp_valid = 1'b0;
        chk("full_occ",        64'(occ),        64'd4);
        chk("full_disp_ready", 64'(disp_ready), 64'd0);
        cdb_valid = 1'b1;
        cdb_tag   = 5'd7;
        cdb_val   = 32'h77;
        tick();
        cdb_valid = 1'b0;
        chk("full_ready_during_issue", 64'(disp_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk("age_issue_valid", 64'(issue_valid), 64'd1);
            tick();
        end
        chk("age_occ_0", 64'(occ), 64'd0);

        // Dispatch-time bypass with backpressure
        issue_ready = 1'b0;
        drive_disp(mk(32'h400, 32'h11, 32'd0, 5'd5, 1'b1, 1'b0), 1'b1, 5'd0, 1'b0, 5'd9);
        cdb_valid = 1'b1;
        cdb_tag   = 5'd9;
        cdb_val   = 32'h1234;
        exp_q.push_back(ex(32'h400, 5'd5, 32'h11, 32'h1234));
        tick();
        disp_valid = 1'b0;
        cdb_valid  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_issue_valid", 64'(issue_valid),        64'd1);
            chk("bp_pc",          64'(issue_data.pc),      64'h400);
            chk("bp_rs2",         64'(issue_data.rs2_val), 64'h1234);
            tick();
        end
        issue_ready = 1'b1;
        tick();
        chk("bp_occ_0", 64'(occ), 64'd0);

        // Flush with two valid entries, a dispatch and an eligible issue pending
        issue_ready = 1'b0;
        drive_disp(mk(32'h500, 32'd1, 32'd1, 5'd8, 1'b1, 1'b0), 1'b1, 5'd0, 1'b1, 5'd0);
        tick();
        drive_disp(mk(32'h504, 32'd2, 32'd2, 5'd9, 1'b1, 1'b0), 1'b1, 5'd0, 1'b1, 5'd0);
        tick();
        chk("pre_flush_occ", 64'(occ), 64'd2);
        flush = 1'b1;
        drive_disp(mk(32'h508, 32'd3, 32'd3, 5'd11, 1'b1, 1'b0), 1'b1, 5'd0, 1'b1, 5'd0);
        issue_ready = 1'b1;
        cdb_valid   = 1'b1;
        cdb_tag     = 5'd0;
        #1;
        chk("flush_disp_ready",  64'(disp_ready),  64'd0);
        chk("flush_issue_valid", 64'(issue_valid), 64'd0);
        tick();
        flush      = 1'b0;
        disp_valid = 1'b0;
        cdb_valid  = 1'b0;
        chk("post_flush_occ", 64'(occ), 64'd0);
        for (int i = 0; i < 2; i++) begin
            chk("post_flush_no_issue", 64'(issue_valid), 64'd0);
            tick();
        end

        // Asynchronous reset with three entries valid
        issue_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_disp(mk(32'h700 + 32'(4 * i), 32'd0, 32'd0, 5'(i), 1'b1, 1'b0),
                       1'b1, 5'd0, 1'b1, 5'd0);
            tick();
        end
        disp_valid = 1'b0;
        chk("pre_reset_occ", 64'(occ), 64'd3);
        reset_n = 1'b0;
        #1;
        chk("async_reset_occ",         64'(occ),         64'd0);
        chk("async_reset_issue_valid", 64'(issue_valid), 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        chk("post_reset_disp_ready", 64'(disp_ready), 64'd1);

        // JALR with rs2 never ready still issues
        issue_ready = 1'b1;
        drive_disp(mk(32'h600, 32'h40, 32'd0, 5'd12, 1'b0, 1'b1), 1'b1, 5'd0, 1'b0, 5'd20);
        exp_q.push_back(ex(32'h600, 5'd12, 32'h40, 32'd0));
        tick();
        disp_valid = 1'b0;
        chk("jalr_issue_valid", 64'(issue_valid), 64'd1);
        tick();
        chk("jalr_occ_0", 64'(occ), 64'd0);

        tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
